// File: rtl/operand_route_arbiter.sv
// rtl/operand_route_arbiter.sv - per-channel operand FIFOs merged by round-robin into one registered output
// Optional macro OPERAND_ROUTE_PRED_PRIO_EN: channels with a predicate (slot 2) at their head are served first.
module operand_route_arbiter #(
   parameter int NUM_CH  = 4,
   parameter int DEPTH   = 4,
   parameter int DATA_W  = 64,
   parameter int INSTR_W = 7,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         in_req,
   output logic [NUM_CH-1:0]         in_ack,
   input  logic [NUM_CH*DATA_W-1:0]  in_operand,
   input  logic [NUM_CH*INSTR_W-1:0] in_dest_instr,
   input  logic [NUM_CH*2-1:0]       in_dest_slot,
   output logic                      out_req,
   input  logic                      out_ack,
   output logic [DATA_W-1:0]         out_operand,
   output logic [INSTR_W-1:0]        out_dest_instr,
   output logic [1:0]                out_dest_slot,
   output logic [NUM_CH-1:0]         ch_full,
   output logic                      slot_err,
   output logic [CNT_W-1:0]          deliver_cnt
);

   localparam int AW   = $clog2(DEPTH);
   localparam int CH_W = $clog2(NUM_CH);
   localparam int EW   = DATA_W + INSTR_W + 2;
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // entry layout: {operand, dest_instr, dest_slot}
   logic [EW-1:0]     mem     [NUM_CH][DEPTH];
   logic [EW-1:0]     head    [NUM_CH];
   logic [AW:0]       wr_ptr  [NUM_CH];
   logic [AW:0]       rd_ptr  [NUM_CH];
   logic [NUM_CH-1:0] not_empty;
   logic [NUM_CH-1:0] push;
   logic [NUM_CH-1:0] bad_slot;
   logic [NUM_CH-1:0] eligible;
   logic [CH_W-1:0]   rr_ptr;
   logic [CH_W-1:0]   grant_idx;
   logic              grant_valid;
   logic              load;
   logic              pop;

   function automatic logic [CH_W-1:0] rr_add(input logic [CH_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_CH) s = s - NUM_CH;
      return CH_W'(s);
   endfunction

   always_comb begin
      ch_full   = '0;
      in_ack    = '0;
      not_empty = '0;
      push      = '0;
      bad_slot  = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_full[i]   = (wr_ptr[i][AW] != rd_ptr[i][AW]) &&
                        (wr_ptr[i][AW-1:0] == rd_ptr[i][AW-1:0]);
         not_empty[i] = (wr_ptr[i] != rd_ptr[i]);
         head[i]      = mem[i][rd_ptr[i][AW-1:0]];
         in_ack[i]    = !ch_full[i];
         bad_slot[i]  = in_req[i] && !ch_full[i] && (in_dest_slot[2*i +: 2] == 2'd3);
         push[i]      = in_req[i] && !ch_full[i] && (in_dest_slot[2*i +: 2] != 2'd3);
      end
   end

`ifdef OPERAND_ROUTE_PRED_PRIO_EN
   logic [NUM_CH-1:0] head_pred;

   always_comb begin
      head_pred = '0;
      for (int i = 0; i < NUM_CH; i++)
         head_pred[i] = not_empty[i] && (head[i][1:0] == 2'd2);
      eligible = (|head_pred) ? head_pred : not_empty;
   end
`else
   always_comb eligible = not_empty;
`endif

   always_comb begin
      grant_valid = 1'b0;
      grant_idx   = '0;
      for (int j = 0; j < NUM_CH; j++) begin
         if (!grant_valid && eligible[rr_add(rr_ptr, j)]) begin
            grant_valid = 1'b1;
            grant_idx   = rr_add(rr_ptr, j);
         end
      end
   end

   assign load = !out_req || out_ack;
   assign pop  = load && grant_valid;

   // storage needs no reset: pointers alone define what is valid
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (push[i])
            mem[i][wr_ptr[i][AW-1:0]] <= {in_operand[i*DATA_W +: DATA_W],
                                          in_dest_instr[i*INSTR_W +: INSTR_W],
                                          in_dest_slot[2*i +: 2]};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (push[i])
               wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (pop && (grant_idx == CH_W'(i)))
               rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_req        <= 1'b0;
         out_operand    <= '0;
         out_dest_instr <= '0;
         out_dest_slot  <= '0;
         rr_ptr         <= '0;
         slot_err       <= 1'b0;
         deliver_cnt    <= '0;
      end else begin
         if (out_req && out_ack)
            deliver_cnt <= deliver_cnt + CNT_W'(1);
         if (|bad_slot)
            slot_err <= 1'b1;
         if (load) begin
            if (grant_valid) begin
               out_req        <= 1'b1;
               out_operand    <= head[grant_idx][EW-1 -: DATA_W];
               out_dest_instr <= head[grant_idx][INSTR_W+1:2];
               out_dest_slot  <= head[grant_idx][1:0];
               rr_ptr         <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
            end else begin
               out_req <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_operand_route_arbiter.sv
// tb/tb_operand_route_arbiter.sv - self-checking bench for operand_route_arbiter
module tb_operand_route_arbiter;

   localparam int NUM_CH  = 4;
   localparam int DEPTH   = 4;
   localparam int DATA_W  = 64;
   localparam int INSTR_W = 7;
   localparam int CNT_W   = 16;
   localparam int EW      = DATA_W + INSTR_W + 2;

   logic                      clk = 1'b0;
   logic                      rst = 1'b0;
   logic [NUM_CH-1:0]         in_req;
   logic [NUM_CH-1:0]         in_ack;
   logic [NUM_CH*DATA_W-1:0]  in_operand;
   logic [NUM_CH*INSTR_W-1:0] in_dest_instr;
   logic [NUM_CH*2-1:0]       in_dest_slot;
   logic                      out_req;
   logic                      out_ack;
   logic [DATA_W-1:0]         out_operand;
   logic [INSTR_W-1:0]        out_dest_instr;
   logic [1:0]                out_dest_slot;
   logic [NUM_CH-1:0]         ch_full;
   logic                      slot_err;
   logic [CNT_W-1:0]          deliver_cnt;

   operand_route_arbiter #(
      .NUM_CH(NUM_CH), .DEPTH(DEPTH), .DATA_W(DATA_W), .INSTR_W(INSTR_W), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .in_req(in_req), .in_ack(in_ack), .in_operand(in_operand),
      .in_dest_instr(in_dest_instr), .in_dest_slot(in_dest_slot),
      .out_req(out_req), .out_ack(out_ack), .out_operand(out_operand),
      .out_dest_instr(out_dest_instr), .out_dest_slot(out_dest_slot),
      .ch_full(ch_full), .slot_err(slot_err), .deliver_cnt(deliver_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DATA_W-1:0] log_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // reference model: one queue per channel plus a one-entry output holding slot
   logic [EW-1:0]    mq[NUM_CH][$];
   logic             m_req = 1'b0;
   logic [EW-1:0]    m_out = '0;
   int               m_rr  = 0;
   logic             m_err = 1'b0;
   logic [CNT_W-1:0] m_cnt = '0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) mq[i].delete();
         m_req = 1'b0; m_out = '0; m_rr = 0; m_err = 1'b0; m_cnt = '0;
      end else begin
         bit [NUM_CH-1:0] acc;
         int pick, c;
         bit any_pred;
         logic [EW-1:0] h;
         for (int i = 0; i < NUM_CH; i++) acc[i] = in_req[i] && (mq[i].size() < DEPTH);
         if (m_req && out_ack) m_cnt = m_cnt + 1'b1;
         if (!m_req || out_ack) begin
            pick = -1;
            any_pred = 1'b0;
`ifdef OPERAND_ROUTE_PRED_PRIO_EN
            for (int i = 0; i < NUM_CH; i++)
               if (mq[i].size() > 0) begin
                  h = mq[i][0];
                  if (h[1:0] == 2'd2) any_pred = 1'b1;
               end
`endif
            for (int j = 0; j < NUM_CH; j++) begin
               c = (m_rr + j) % NUM_CH;
               if (pick < 0 && mq[c].size() > 0) begin
                  h = mq[c][0];
                  if (!any_pred || h[1:0] == 2'd2) pick = c;
               end
            end
            if (pick >= 0) begin
               m_out = mq[pick].pop_front();
               m_req = 1'b1;
               m_rr  = (pick + 1) % NUM_CH;
            end else begin
               m_req = 1'b0;
            end
         end
         for (int i = 0; i < NUM_CH; i++)
            if (acc[i]) begin
               if (in_dest_slot[2*i +: 2] == 2'd3) m_err = 1'b1;
               else mq[i].push_back({in_operand[i*DATA_W +: DATA_W],
                                     in_dest_instr[i*INSTR_W +: INSTR_W],
                                     in_dest_slot[2*i +: 2]});
            end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < NUM_CH; i++) begin
         chk($sformatf("in_ack[%0d]", i), in_ack[i], mq[i].size() < DEPTH);
         chk($sformatf("ch_full[%0d]", i), ch_full[i], mq[i].size() == DEPTH);
      end
      chk("out_req", out_req, m_req);
      chk("out_operand", out_operand, m_out[EW-1 -: DATA_W]);
      chk("out_dest_instr", out_dest_instr, m_out[INSTR_W+1:2]);
      chk("out_dest_slot", out_dest_slot, m_out[1:0]);
      chk("slot_err", slot_err, m_err);
      chk("deliver_cnt", deliver_cnt, m_cnt);
   end

   always @(posedge clk)
      if (!rst && out_req && out_ack) log_q.push_back(out_operand);

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int ch, input logic [63:0] op, input logic [6:0] ins, input logic [1:0] sl);
      bit acked;
      int n;
      in_operand[ch*DATA_W +: DATA_W]      = op;
      in_dest_instr[ch*INSTR_W +: INSTR_W] = ins;
      in_dest_slot[2*ch +: 2]              = sl;
      in_req[ch] = 1'b1;
      acked = 1'b0;
      n = 0;
      while (!acked && n < 200) begin
         @(negedge clk);
         acked = in_ack[ch];
         @(posedge clk);
         #1;
         n++;
      end
      in_req[ch] = 1'b0;
      if (!acked) chk($sformatf("push_timeout_ch%0d", ch), 64'd0, 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      log_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      in_req = '0; in_operand = '0; in_dest_instr = '0; in_dest_slot = '0; out_ack = 1'b0;
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("rst_out_req", out_req, 0);
      chk("rst_in_ack", in_ack, 4'hF);
      chk("rst_ch_full", ch_full, 0);
      chk("rst_deliver_cnt", deliver_cnt, 0);

      // single operand latency
      out_ack = 1'b1;
      push(1, 64'h1234, 7'd5, 2'd0);
      chk("lat_early_req", out_req, 0);
      cycles(1);
      chk("lat_req", out_req, 1);
      chk("lat_operand", out_operand, 64'h1234);
      chk("lat_instr", out_dest_instr, 5);
      chk("lat_slot", out_dest_slot, 0);
      chk("lat_cnt0", deliver_cnt, 0);
      cycles(1);
      chk("lat_cnt1", deliver_cnt, 1);
      chk("lat_req_clear", out_req, 0);

      // fairness: all channels streaming
      do_reset();
      fork
         for (int k = 0; k < 4; k++) push(0, 64'(16*0 + k), 7'(k), 2'd0);
         for (int k = 0; k < 4; k++) push(1, 64'(16*1 + k), 7'(k), 2'd1);
         for (int k = 0; k < 4; k++) push(2, 64'(16*2 + k), 7'(k), 2'd0);
         for (int k = 0; k < 4; k++) push(3, 64'(16*3 + k), 7'(k), 2'd1);
      join
      cycles(20);
      chk("fair_count", log_q.size(), 16);
      chk("fair_cnt", deliver_cnt, 16);
      for (int n = 0; n < 16 && n < log_q.size(); n++)
         chk($sformatf("fair_order[%0d]", n), log_q[n], 64'((n % 4) * 16 + n / 4));

      // backpressure fills channel 0
      do_reset();
      out_ack = 1'b0;
      for (int k = 0; k < 5; k++) push(0, 64'(8'hA0 + k), 7'(k), 2'd0);
      in_req[0] = 1'b1;
      @(negedge clk);
      #1;
      chk("bp_full", ch_full[0], 1);
      chk("bp_ack", in_ack[0], 0);
      in_req[0] = 1'b0;
      @(posedge clk);
      #1;
      out_ack = 1'b1;
      cycles(10);
      chk("bp_count", log_q.size(), 5);
      for (int n = 0; n < 5 && n < log_q.size(); n++)
         chk($sformatf("bp_order[%0d]", n), log_q[n], 64'(8'hA0 + n));

      // illegal slot is swallowed
      do_reset();
      push(2, 64'hDEAD, 7'd3, 2'd3);
      chk("ill_err", slot_err, 1);
      cycles(5);
      chk("ill_none_out", log_q.size(), 0);
      chk("ill_err_sticky", slot_err, 1);

      // async reset with data in flight
      do_reset();
      chk("rst_clears_err", slot_err, 0);
      push(1, 64'hB8, 7'd0, 2'd0);
      push(1, 64'hB9, 7'd0, 2'd0);
      cycles(3);
      out_ack = 1'b0;
      for (int k = 0; k < 4; k++) push(1, 64'(8'hB0 + k), 7'(k), 2'd0);
      chk("mid_req", out_req, 1);
      chk("mid_cnt", deliver_cnt, 2);
      #2 rst = 1'b1;
      #1;
      chk("async_out_req", out_req, 0);
      chk("async_ch_full", ch_full, 0);
      chk("async_cnt", deliver_cnt, 0);
      chk("async_in_ack", in_ack, 4'hF);
      chk("async_operand", out_operand, 0);
      @(posedge clk);
      #3 rst = 1'b0;
      log_q.delete();
      out_ack = 1'b1;
      cycles(6);
      chk("async_no_stale", log_q.size(), 0);
      chk("async_req_idle", out_req, 0);

      // predicate head vs data head, rr_ptr at 0
      do_reset();
      fork
         push(0, 64'hC0, 7'd1, 2'd0);
         push(3, 64'hC3, 7'd2, 2'd2);
      join
      cycles(4);
      chk("pred_count", log_q.size(), 2);
      if (log_q.size() >= 2) begin
`ifdef OPERAND_ROUTE_PRED_PRIO_EN
         chk("pred_first", log_q[0], 64'hC3);
         chk("pred_second", log_q[1], 64'hC0);
`else
         chk("plain_first", log_q[0], 64'hC0);
         chk("plain_second", log_q[1], 64'hC3);
`endif
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/operand_route_arbiter.md
Name: operand_route_arbiter

Overview:
- N-channel operand concentrator for the E-node operand network.
- Merges NUM_CH sender-side operand streams (operand payload, dest instr, dest slot; req/ack) into one receiver-side stream.
- Each channel has its own FIFO, and a round-robin arbiter picks which FIFO feeds the registered output stage.
- Sits in front of each E-tile's reservation stations; generalises the single point-to-point operand link to multiple channels with buffering.

Parameters:
- NUM_CH, 4, number of input channels (2..8)
- DEPTH, 4, entries per channel FIFO (power of two, >=2)
- DATA_W, 64, operand payload width (value plus metadata)
- INSTR_W, 7, destination instruction number width
- CNT_W, 16, delivered-operand counter width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_req  in  NUM_CH  per-channel request
- in_ack  out  NUM_CH  per-channel accept
- in_operand  in  NUM_CH*DATA_W  payloads; channel i at bits [i*DATA_W +: DATA_W]
- in_dest_instr  in  NUM_CH*INSTR_W  destination instr numbers
- in_dest_slot  in  NUM_CH*2  slot: 0 left, 1 right, 2 predicate, 3 illegal
- out_req  out  1  output holds valid operand
- out_ack  in  1  receiver accepts
- out_operand  out  DATA_W  output payload
- out_dest_instr  out  INSTR_W  output dest instr
- out_dest_slot  out  2  output slot
- ch_full  out  NUM_CH  FIFO full per channel
- slot_err  out  1  sticky: illegal slot seen
- deliver_cnt  out  CNT_W  count of completed output transfers

Behaviour:
- Transfer rule: a transfer occurs on a rising edge where req and ack are both 1 (input and output alike). A sender must hold req and its fields stable until acked.
- in_ack[i] = !ch_full[i] (combinational from occupancy only; no pass-through when full). A push to a full FIFO is impossible even if a pop occurs in the same cycle.
- Illegal slot: an input accepted with slot==3 is consumed (acked) but not enqueued. slot_err is set and stays set until reset.
- FIFO: read/write pointers of log2(DEPTH)+1 bits, wrap-around via MSB. Full and empty are derived from the pointers. Simultaneous push and pop on a non-empty FIFO leaves occupancy unchanged.
- Output stage is one register:
  - "load" = output empty, or (out_req && out_ack) in the same cycle.
  - On load with any FIFO non-empty: the round-robin winner is popped into the output register, and out_req is 1 next cycle.
  - On load with none non-empty: out_req clears to 0.
  - While out_req && !out_ack: the register holds and no pop occurs.
- Round-robin:
  - Search starts at rr_ptr and wraps NUM_CH-1 -> 0.
  - After a grant to channel k, rr_ptr = (k+1) mod NUM_CH.
  - rr_ptr is unchanged when there is no grant.
- Latency: an operand accepted at edge t, with the output empty, appears with out_req=1 after edge t+1 (two-edge latency). Back-to-back throughput is 1 operand per cycle while out_ack is held at 1.
- deliver_cnt increments on each out_req&&out_ack and wraps from 2^CNT_W-1 to 0.
- Reset (asynchronous, any time, including mid-transfer):
  - FIFOs are emptied, rr_ptr=0, out_req=0.
  - out_operand, out_dest_instr and out_dest_slot are 0.
  - slot_err=0, deliver_cnt=0.
  - in_ack is all 1s after reset; ch_full is 0.
  - In-flight operands are discarded.

Optional Feature:
- Macro: OPERAND_ROUTE_PRED_PRIO_EN.
- Defined: arbitration is two-level. If any non-empty FIFO has a predicate operand (slot==2) at its head, only those channels compete (round-robin from rr_ptr), so predicates reach the E-node ahead of data operands. Otherwise plain round-robin applies. rr_ptr updates on every grant as normal.
- Undefined: plain round-robin only; slot is ignored for arbitration.

Test Plan:
- Reset, then single op: ch1 pushes operand 0x1234, instr 5, slot 0 at edge t with out_ack=1 → out_req=1 after edge t+1 with those fields; deliver_cnt=1 after edge t+2.
- Fairness: all 4 channels continuously requesting, out_ack=1 → grants in order 0,1,2,3,0,... with one output per cycle; no channel starves over 16 cycles.
- Backpressure: out_ack=0, ch0 pushes 5 operands (DEPTH=4) → 1 taken into the output register, 4 buffered, ch_full[0]=1 and in_ack[0]=0 at the 6th request. Raising out_ack drains all 5 in push order.
- Illegal slot: ch2 sends slot=3 → in_ack[2]=1, nothing appears on the output, slot_err=1 and remains 1 until rst.
- Async reset mid-stream: assert rst between edges while out_req=1 with 3 entries queued → out_req=0, ch_full=0 and deliver_cnt=0 immediately; no stale operand emerges after rst deasserts.
- With OPERAND_ROUTE_PRED_PRIO_EN: out_ack held at 1 while 0 channels hold data; ch0 head slot 0, ch3 head slot 2, rr_ptr=0 → ch3 is granted first, then ch0.
